// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and digit helpers for the BCD down-counting timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    localparam int BCD_W = 4;

    // Odd-index digits are the tens of seconds/minutes in mm:ss
    function automatic int digit_mod(input int i, input int time_mode);
        return ((time_mode != 0) && (i % 2 == 1)) ? 6 : 10;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] value,
                                                     input int mod);
        logic [BCD_W-1:0] max_v;
        max_v = BCD_W'(mod - 1);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit: clear, clamped load and decrement with wrap to MOD-1
module bcd_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    output logic [BCD_W-1:0] val,
    output logic             is_zero
);

    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MOD - 1);

    logic [BCD_W-1:0] val_q;
    logic [BCD_W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (ld) begin
            val_d = clamp_digit(ld_val, MOD);
        end else if (dec) begin
            val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val     = val_q;
    assign is_zero = (val_q == '0);

endmodule

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - multi-digit BCD down timer with run/pause FSM and saturating expiry
module bcd_timer
    import timer_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TIME_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] data,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    state_e state_q;
    state_e state_d;
    logic   done_q;
    logic   done_d;

    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] lower_zero;
    logic              count_nz;
    logic              ld_en;
    logic              do_tick;
    logic              expire;

    assign count_nz = |count;
    assign ld_en    = load & ~clear & (state_q != RUN);
    // stop and clear both steal the tick; a zero count never decrements
    assign do_tick  = tick & (state_q == RUN) & ~stop & ~clear & count_nz;
    assign expire   = do_tick & (count == (BCD_W*DIGITS)'(1));

    always_comb begin
        lower_zero[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            lower_zero[i] = lower_zero[i-1] & digit_zero[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit #(
            .MOD(digit_mod(g, TIME_MODE))
        ) u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clear),
            .ld     (ld_en),
            .ld_val (data[BCD_W*g +: BCD_W]),
            .dec    (do_tick & lower_zero[g]),
            .val    (count[BCD_W*g +: BCD_W]),
            .is_zero(digit_zero[g])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (ld_en) begin
            state_d = state_q;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start && (state_q != RUN)) begin
            if (count_nz) begin
                state_d = RUN;
            end
        end else if (expire) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign zero    = ~count_nz;
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - directed self-checking bench for bcd_timer in mm:ss and decimal modes
module tb_bcd_timer;

    logic        clk = 1'b0;
    logic        rst, tick, load, start, stop, clear;
    logic [15:0] data;
    logic [15:0] count_t, count_d;
    logic        zero_t, zero_d, running_t, running_d, done_t, done_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_timer #(.DIGITS(4), .TIME_MODE(1)) u_dut_t (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .data(data),
        .start(start), .stop(stop), .clear(clear),
        .count(count_t), .zero(zero_t), .running(running_t), .done(done_t)
    );

    bcd_timer #(.DIGITS(4), .TIME_MODE(0)) u_dut_d (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .data(data),
        .start(start), .stop(stop), .clear(clear),
        .count(count_d), .zero(zero_d), .running(running_d), .done(done_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply the currently driven inputs for one edge, then release all strobes
    task automatic step();
        @(posedge clk);
        #1;
        rst = 0; tick = 0; load = 0; start = 0; stop = 0; clear = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        data = v; load = 1; step();
    endtask

    initial begin
        rst = 1; tick = 0; load = 0; start = 0; stop = 0; clear = 0; data = '0;
        step();
        check("rst_count", count_t, 16'h0000);
        check("rst_zero", zero_t, 1);
        check("rst_running", running_t, 0);
        check("rst_done", done_t, 0);

        // mm:ss borrow
        do_load(16'h0100);
        start = 1; step();
        check("borrow_run", running_t, 1);
        tick = 1; step();
        check("borrow_count", count_t, 16'h0059);
        check("borrow_running", running_t, 1);
        check("borrow_done", done_t, 0);
        clear = 1; step();

        // expiry and saturation
        do_load(16'h0002);
        start = 1; step();
        tick = 1; step();
        check("exp_one", count_t, 16'h0001);
        check("exp_done_early", done_t, 0);
        tick = 1; step();
        check("exp_count", count_t, 16'h0000);
        check("exp_done", done_t, 1);
        check("exp_running", running_t, 0);
        check("exp_zero", zero_t, 1);
        for (int i = 0; i < 3; i++) begin
            tick = 1; step();
            check("sat_count", count_t, 16'h0000);
            check("sat_done", done_t, 0);
        end

        // clamping
        do_load(16'h0199);
        check("clamp_t", count_t, 16'h0159);
        check("clamp_d", count_d, 16'h0199);
        do_load(16'h00FA);
        check("clamp_fa_t", count_t, 16'h0059);
        check("clamp_fa_d", count_d, 16'h0099);

        // pause and resume
        do_load(16'h0030);
        start = 1; step();
        tick = 1; step();
        check("pr_first", count_t, 16'h0029);
        stop = 1; tick = 1; step();
        check("pr_stop_tick", count_t, 16'h0029);
        check("pr_paused", running_t, 0);
        for (int i = 0; i < 3; i++) begin
            tick = 1; step();
        end
        check("pr_hold", count_t, 16'h0029);
        do_load(16'h0500);
        check("pr_reload", count_t, 16'h0500);
        start = 1; tick = 1; step();
        check("pr_start_tick", count_t, 16'h0500);
        check("pr_resumed", running_t, 1);
        tick = 1; step();
        check("pr_tick_t", count_t, 16'h0459);
        check("pr_tick_d", count_d, 16'h0499);
        stop = 1; step();
        start = 1; stop = 1; step();
        check("pr_start_stop", running_t, 0);

        // overrides
        clear = 1; step();
        do_load(16'h0046);
        start = 1; step();
        tick = 1; step();
        check("ov_pre_clear", count_t, 16'h0045);
        clear = 1; tick = 1; step();
        check("ov_clear_count", count_t, 16'h0000);
        check("ov_clear_running", running_t, 0);
        check("ov_clear_done", done_t, 0);
        start = 1; step();
        check("ov_start_zero", running_t, 0);
        do_load(16'h0001);
        start = 1; step();
        rst = 1; tick = 1; step();
        check("ov_rst_count", count_t, 16'h0000);
        check("ov_rst_running", running_t, 0);
        check("ov_rst_done", done_t, 0);
        step();
        check("ov_rst_done2", done_t, 0);
        do_load(16'h0001);
        start = 1; step();
        clear = 1; tick = 1; step();
        check("ov_clr_exp_done", done_t, 0);
        check("ov_clr_exp_count", count_t, 16'h0000);
        do_load(16'h0010);
        start = 1; step();
        do_load(16'h0077);
        check("ov_load_run", count_t, 16'h0010);
        check("ov_load_run_state", running_t, 1);
        clear = 1; step();

        // decimal wrap
        do_load(16'h1000);
        start = 1; step();
        tick = 1; step();
        check("dec_wrap_d", count_d, 16'h0999);
        check("dec_wrap_t", count_t, 16'h0959);
        check("dec_wrap_run", running_d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
